// File: rtl/vga_pkg.sv
// 640x480@60 raster constants and the coordinate type shared with the
// sprite/character drivers and the colour compositor.
package vga_pkg;

   localparam int COORD_W = 11;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
   localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
   localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
   localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable: tick is high for one clk out of every CLK_DIV.
// With CLK_DIV = 1 the divider never leaves 0, so tick is constantly high.
module pixel_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel enable, h/v counters, sync decode and
// line/frame strobes, all registered so outputs never see a combinational input path.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   CLK_DIV  = 4,
   parameter int   H_ACTIVE = VGA_H_ACTIVE,
   parameter int   H_FP     = VGA_H_FP,
   parameter int   H_SYNC   = VGA_H_SYNC,
   parameter int   H_BP     = VGA_H_BP,
   parameter int   V_ACTIVE = VGA_V_ACTIVE,
   parameter int   V_FP     = VGA_V_FP,
   parameter int   V_SYNC   = VGA_V_SYNC,
   parameter int   V_BP     = VGA_V_BP,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic   clk,
   input  logic   rst,
   output coord_t drawX,
   output coord_t drawY,
   output logic   hsync,
   output logic   vsync,
   output logic   active,
   output logic   pix_en,
   output logic   line_tick,
   output logic   frame_tick
);

   localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
   localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
   localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

   logic   tick;
   logic   h_wrap;
   logic   v_wrap;
   coord_t h_next;
   coord_t v_next;

   function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
      return (v >= lo) && (v < hi);
   endfunction

   pixel_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // Next position; the vertical counter only moves on a horizontal wrap.
   always_comb begin
      h_wrap = (drawX == H_LAST);
      v_wrap = (drawY == V_LAST);
      h_next = h_wrap ? '0 : drawX + 1'b1;
      v_next = drawY;
      if (h_wrap) begin
         v_next = v_wrap ? '0 : drawY + 1'b1;
      end
   end

   // Reset parks the counters on the last position so the first tick lands on (0,0) with full strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drawX      <= H_LAST;
         drawY      <= V_LAST;
         hsync      <= ~SYNC_POL;
         vsync      <= ~SYNC_POL;
         active     <= 1'b0;
         pix_en     <= 1'b0;
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         pix_en     <= tick;
         line_tick  <= tick && h_wrap;
         frame_tick <= tick && h_wrap && v_wrap;
         if (tick) begin
            drawX  <= h_next;
            drawY  <= v_next;
            hsync  <= in_window(h_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync  <= in_window(v_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
            active <= (h_next < H_ACT) && (v_next < V_ACT);
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 640x480 timing at CLK_DIV=4 for the horizontal
// scan, plus two reduced rasters (CLK_DIV=3 and CLK_DIV=1, inverted sync) for frames and reset.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        hs;
      logic        vs;
      logic        act;
      logic        pe;
      logic        lt;
      logic        ft;
   } exp_t;

   logic clk = 1'b0;
   logic rst0, rst1, rst2;
   always #5 clk = ~clk;

   logic [10:0] x0, y0, x1, y1, x2, y2;
   logic hs0, vs0, act0, pe0, lt0, ft0;
   logic hs1, vs1, act1, pe1, lt1, ft1;
   logic hs2, vs2, act2, pe2, lt2, ft2;

   int checks = 0;
   int errors = 0;

   vga_timing_gen #(.CLK_DIV(4)) u0 (
      .clk(clk), .rst(rst0), .drawX(x0), .drawY(y0), .hsync(hs0), .vsync(vs0),
      .active(act0), .pix_en(pe0), .line_tick(lt0), .frame_tick(ft0));

   vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)) u1 (
      .clk(clk), .rst(rst1), .drawX(x1), .drawY(y1), .hsync(hs1), .vsync(vs1),
      .active(act1), .pix_en(pe1), .line_tick(lt1), .frame_tick(ft1));

   vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)) u2 (
      .clk(clk), .rst(rst2), .drawX(x2), .drawY(y2), .hsync(hs2), .vsync(vs2),
      .active(act2), .pix_en(pe2), .line_tick(lt2), .frame_tick(ft2));

   // Rising edges since reset released, per instance.
   longint e0, e1, e2;
   always @(posedge clk or posedge rst0) if (rst0) e0 <= 0; else e0 <= e0 + 1;
   always @(posedge clk or posedge rst1) if (rst1) e1 <= 0; else e1 <= e1 + 1;
   always @(posedge clk or posedge rst2) if (rst2) e2 <= 0; else e2 <= e2 + 1;

   // Position after e edges: pixel index p = e/d - 1, then x/y by modulo; before
   // the first pixel the raster sits at the last position with no strobes.
   function automatic exp_t model(input longint e, input int d,
                                  input int ha, input int hfp, input int hsw, input int hbp,
                                  input int va, input int vfp, input int vsw, input int vbp,
                                  input logic pol);
      exp_t r;
      int ht, vt, x, y;
      longint p;
      logic pe;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      if (e < d) begin
         x = ht - 1; y = vt - 1; pe = 1'b0;
      end else begin
         p  = e / d - 1;
         x  = int'(p % ht);
         y  = int'((p / ht) % vt);
         pe = (e % d) == 0;
      end
      r.x   = 11'(x);
      r.y   = 11'(y);
      r.hs  = (x >= ha + hfp && x < ha + hfp + hsw) ? pol : ~pol;
      r.vs  = (y >= va + vfp && y < va + vfp + vsw) ? pol : ~pol;
      r.act = (x < ha) && (y < va);
      r.pe  = pe;
      r.lt  = pe && (x == 0);
      r.ft  = pe && (x == 0) && (y == 0);
      return r;
   endfunction

   function automatic exp_t m0(input longint e);
      return model(e, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction
   function automatic exp_t m1(input longint e);
      return model(e, 3, 16, 2, 3, 3, 6, 2, 2, 2, 1'b0);
   endfunction
   function automatic exp_t m2(input longint e);
      return model(e, 1, 16, 2, 3, 3, 6, 2, 2, 2, 1'b1);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Statistics gathered alongside the per-cycle comparison.
   int     hlow0 = 0, hfirst0 = -1, actcnt0 = 0;
   int     acnt1 = 0, vlow1 = 0, frames1 = 0;
   bit     have1 = 0, havel2 = 0, havef2 = 0;
   longint last1 = 0, lastl2 = 0, lastf2 = 0;

   always @(negedge clk) begin
      chk($sformatf("u0 e=%0d", e0), {x0, y0, hs0, vs0, act0, pe0, lt0, ft0}, m0(e0));
      chk($sformatf("u1 e=%0d", e1), {x1, y1, hs1, vs1, act1, pe1, lt1, ft1}, m1(e1));
      chk($sformatf("u2 e=%0d", e2), {x2, y2, hs2, vs2, act2, pe2, lt2, ft2}, m2(e2));

      if (!rst0 && pe0 && y0 == 0 && e0 < 4 * 801) begin
         if (!hs0) begin
            hlow0++;
            if (hfirst0 < 0) hfirst0 = int'(x0);
         end
         if (act0) actcnt0++;
      end

      if (rst1) begin
         have1 = 0;
      end else if (pe1) begin
         if (ft1) begin
            if (have1) begin
               chk("u1 frame period clks", e1 - last1, 864);
               chk("u1 active pixels per frame", acnt1, 96);
               chk("u1 vsync low pixels per frame", vlow1, 48);
               frames1++;
            end
            have1 = 1; last1 = e1; acnt1 = 0; vlow1 = 0;
         end
         if (act1) acnt1++;
         if (!vs1) vlow1++;
      end

      if (!rst2 && lt2) begin
         if (havel2) chk("u2 line period clks", e2 - lastl2, 24);
         havel2 = 1; lastl2 = e2;
      end
      if (!rst2 && ft2) begin
         if (havef2) chk("u2 frame period clks", e2 - lastf2, 288);
         havef2 = 1; lastf2 = e2;
      end
   end

   initial begin
      bit found;
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

      // Model pinned against hand-computed positions.
      chk("model d4 e3", m0(3), {11'd799, 11'd524, 6'b110000});
      chk("model d4 e4", m0(4), {11'd0, 11'd0, 6'b111111});
      chk("model d4 x656", m0(2628), {11'd656, 11'd0, 6'b010100});
      chk("model d4 y490", m0(1568004), {11'd0, 11'd490, 6'b100110});
      chk("model d1 pol1 y8", m2(193), {11'd0, 11'd8, 6'b010110});

      repeat (3) @(negedge clk);
      chk("reset drawX", x0, 799);
      chk("reset drawY", y0, 524);
      chk("reset syncs/active/strobes", {hs0, vs0, act0, pe0, lt0, ft0}, 6'b110000);

      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      @(negedge clk);
      chk("d1 first pixel edge1", {x2, y2, pe2, lt2, ft2}, {11'd0, 11'd0, 3'b111});
      chk("d4 edge1 holds", x0, 799);
      repeat (2) @(negedge clk);
      chk("d4 edge3 no pix_en", {x0, pe0}, {11'd799, 1'b0});
      @(negedge clk);
      chk("d4 edge4 first pixel", {x0, y0, act0, pe0, lt0, ft0}, {11'd0, 11'd0, 4'b1111});
      @(negedge clk);
      chk("d4 edge5 strobes one clk", {x0, pe0, lt0, ft0}, {11'd0, 3'b000});

      repeat (3300) @(negedge clk);
      chk("line0 hsync low pixels", hlow0, 96);
      chk("line0 hsync first drawX", hfirst0, 656);
      chk("line0 active pixels", actcnt0, 640);
      chk("u1 frames measured >=3", frames1 >= 3, 1);

      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(negedge clk);
         if (x1 == 11'd10 && y1 == 11'd4) found = 1;
      end
      chk("u1 reached (10,4)", found, 1);

      @(posedge clk);
      #1 rst1 = 1'b1;
      #1 chk("async reset values", {x1, y1, hs1, vs1, act1, pe1, lt1, ft1},
             {11'd23, 11'd11, 6'b110000});
      repeat (3) @(posedge clk);
      @(negedge clk) rst1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("restart edge2 holds", {x1, y1, pe1}, {11'd23, 11'd11, 1'b0});
      @(negedge clk);
      chk("restart edge3 first pixel", {x1, y1, act1, pe1, lt1, ft1}, {11'd0, 11'd0, 4'b1111});

      repeat (1000) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 display path. Divides the system clock into a pixel-rate enable, runs horizontal and vertical counters, and drives `hsync`, `vsync`, `drawX`, `drawY`, `active`, and the line and frame strobes. It sits directly upstream of the sprite/character drivers and the colour compositor, which consume `drawX`/`drawY`; `frame_tick` is their once-per-frame motion-update strobe.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz to 25 MHz); legal range 1..16.
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing in pixels, H_TOTAL = 800.
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing in lines, V_TOTAL = 525.
- `SYNC_POL`, 0: sync level during the sync interval (0 = active-low).
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `drawX` out 11: current pixel column, 0..H_TOTAL-1.
- `drawY` out 11: current line, 0..V_TOTAL-1.
- `hsync` out 1: horizontal sync.
- `vsync` out 1: vertical sync.
- `active` out 1: high when drawX < H_ACTIVE and drawY < V_ACTIVE.
- `pix_en` out 1: one-clk pulse, high in the first clk a new pixel position is presented.
- `line_tick` out 1: one-clk pulse coincident with pix_en when drawX becomes 0.
- `frame_tick` out 1: one-clk pulse coincident with pix_en when drawX and drawY both become 0.

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps. Internal `tick` = (div == CLK_DIV-1). When CLK_DIV = 1, tick is constantly 1.
- On tick, hcnt increments. At H_TOTAL-1, hcnt wraps to 0 and vcnt increments. At V_TOTAL-1, vcnt wraps to 0.
- Between ticks all counters and derived outputs hold their values.
- `drawX` and `drawY` are the hcnt and vcnt registers themselves; no clamping in blanking.
- `hsync` = SYNC_POL when drawX is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656, 752); otherwise ~SYNC_POL.
- `vsync` = SYNC_POL when drawY is in [490, 492); otherwise ~SYNC_POL.
- `hsync`, `vsync`, and `active` are registered from the next-state counter values, so they are aligned with `drawX`/`drawY` in every clk.
- `pix_en`, `line_tick`, and `frame_tick` are registered from tick and the wrap conditions. Each is high for exactly one clk.

## Timing
- Reset values: div = 0, drawX = H_TOTAL-1 (799), drawY = V_TOTAL-1 (524), hsync = vsync = ~SYNC_POL, active = 0, pix_en = line_tick = frame_tick = 0.
- The first valid position is produced at rising edge number CLK_DIV after reset deasserts. From that clk, drawX = 0, drawY = 0, active = 1, and pix_en, line_tick, frame_tick = 1. So every frame, including the first, begins with frame_tick.
- Steady state: pix_en period = CLK_DIV clks; line_tick period = 800·CLK_DIV; frame_tick period = 420000·CLK_DIV.
- Latency from tick to updated outputs is 1 clk. Outputs have no combinational path from any input.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). The sequence restarts as at power-up; no partial strobes.
- Every wrap is an exact modulo. The vertical wrap occurs only on the same tick as a horizontal wrap.

## Structure
- Shared package `vga_pkg` holds the 640x480 timing constants (active, porch, sync, totals), the derived sync start/end values, and the `coord_t` typedef (logic [10:0]) used by drawX/drawY here and by all downstream drivers.
- One sub-module, `pixel_tick_gen`: the CLK_DIV divider producing `tick`, with the same clk/rst.
- Counters, sync decode, and strobe registers live in `vga_timing_gen`.

## Test plan
- **Reset/first pixel.** Release rst with CLK_DIV = 4 and check reset values. At edge 4: drawX = 0, drawY = 0, active = 1, and pix_en, line_tick, frame_tick all pulse for 1 clk.
- **Horizontal timing.** Over line 0: hsync low for exactly 96 pix_en pulses starting at drawX = 656. drawX runs 0..799 then wraps to 0 with line_tick. active is low from drawX = 640.
- **Vertical timing.** vsync low only for drawY = 490 and 491, i.e. 1600 pix_en pulses. drawY wraps 524 to 0 together with frame_tick.
- **Frame accounting.** Over 3 frames: exactly 1,680,000 clks between frame_ticks, and exactly 307,200 pix_en pulses with active = 1 per frame.
- **Mid-frame reset.** Assert rst at drawX = 300, drawY = 200 for 3 clks. Outputs return to reset values asynchronously. Restart timing is identical to the first-pixel scenario.
- **CLK_DIV = 1.** After reset, pix_en is high every clk and the first pixel appears at edge 1. Line period is 800 clks and frame period is 420,000 clks.
